// File: rtl/cursor_cascade_ctrl.sv
// Cursor controller for cascaded display boards: debounced left/right buttons, carry/borrow cascade, digit-scan select.
// Build macro AUTO_REPEAT_EN adds hold-to-repeat stepping on both buttons.
module cursor_cascade_ctrl #(
  parameter int NPOS       = 8,
  parameter int POS_W      = 3,
  parameter int CASC_W     = 5,
  parameter int WRAP       = 1,
  parameter int DEB_CYCLES = 4,
  parameter int NDIGITS    = 8,
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 16
) (
  input  logic              clk,
  input  logic              resetbutton,
  input  logic              leftbutton,
  input  logic              rightbutton,
  input  logic [CASC_W-1:0] left_in,
  output logic [CASC_W-1:0] right_out,
  output logic [POS_W-1:0]  pos_c,
  output logic [SEL_W-1:0]  sel
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SUM_W = POS_W + 2;

  // Bit 0 = left button, bit 1 = right button throughout.
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_level;
  logic [1:0]            r_level_d;
  logic [1:0][DEB_W-1:0] r_deb_cnt;
  logic [1:0]            w_edge;
  logic [1:0]            w_step;

  logic [POS_W-1:0]      r_pos;
  logic [CASC_W-1:0]     r_out;
  logic [SEL_W-1:0]      r_sel;
  logic [PRE_W-1:0]      r_pre;

  logic [SUM_W-1:0]      w_sum;
  logic                  w_neg;
  logic                  w_over;
  logic [POS_W-1:0]      w_pos_nxt;
  logic [CASC_W-1:0]     w_out_nxt;

  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1   <= {rightbutton, leftbutton};
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // The level only flips after DEB_CYCLES consecutive disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_level[i]   <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign w_edge = r_level & ~r_level_d;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_CYCLES   = 1024;
  localparam int REPEAT_PERIOD = 256;
  localparam int REP_W         = $clog2(HOLD_CYCLES);

  logic [1:0][REP_W-1:0] r_rep_cnt;
  logic [1:0]            w_rep;

  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_rep_cnt <= '0;
    end else begin
      // After the first repeat the counter restarts REPEAT_PERIOD short of the threshold.
      for (int i = 0; i < 2; i++) begin
        if (!r_level[i]) begin
          r_rep_cnt[i] <= '0;
        end else if (r_rep_cnt[i] == REP_W'(HOLD_CYCLES - 1)) begin
          r_rep_cnt[i] <= REP_W'(HOLD_CYCLES - REPEAT_PERIOD);
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_rep = '0;
    for (int i = 0; i < 2; i++) begin
      w_rep[i] = r_level[i] && (r_rep_cnt[i] == REP_W'(HOLD_CYCLES - 1));
    end
  end

  assign w_step = w_edge | w_rep;
`else
  assign w_step = w_edge;
`endif

  always_comb begin
    w_sum = SUM_W'(r_pos) + SUM_W'(w_step[1]) + SUM_W'(left_in[0])
          - SUM_W'(w_step[0]) - SUM_W'(left_in[1]);
    w_neg     = w_sum[SUM_W-1];
    w_over    = !w_neg && (w_sum >= SUM_W'(NPOS));
    w_pos_nxt = w_sum[POS_W-1:0];
    w_out_nxt = left_in;
    w_out_nxt[1:0] = 2'b00;
    // Delta is bounded to +/-2 and NPOS >= 3, so one correction is enough.
    if (WRAP != 0) begin
      if (w_neg) begin
        w_pos_nxt      = POS_W'(w_sum + SUM_W'(NPOS));
        w_out_nxt[1:0] = 2'b10;
      end else if (w_over) begin
        w_pos_nxt      = POS_W'(w_sum - SUM_W'(NPOS));
        w_out_nxt[1:0] = 2'b01;
      end
    end else begin
      if (w_neg) begin
        w_pos_nxt = '0;
      end else if (w_over) begin
        w_pos_nxt = POS_W'(NPOS - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_pos <= '0;
      r_out <= '0;
    end else begin
      r_pos <= w_pos_nxt;
      r_out <= w_out_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetbutton) begin
    if (!resetbutton) begin
      r_pre <= '0;
      r_sel <= '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_sel <= (r_sel == SEL_W'(NDIGITS - 1)) ? '0 : r_sel + SEL_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign pos_c     = r_pos;
  assign right_out = r_out;
  assign sel       = r_sel;

endmodule
